// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Produces the pixel/line position counters, the hsync/vsync/display_on
// qualifiers, line/frame start strobes and a free-running frame counter.
// The sync qualifiers are computed from the next-state counters, so they
// always describe the hpos/vpos presented on the same cycle.
// Optional macro VGA_TIMING_ALIGN_EN: when defined, hsync, vsync, display_on,
// line_start and frame_start each pass through a SYNC_DELAY-stage clk shift
// register to line up with pipelined downstream pixel logic.
module vga_timing_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_BOTTOM   = 10,
  parameter int V_SYNC     = 2,
  parameter int V_TOP      = 33,
  parameter bit HS_ACTIVE  = 1'b1,
  parameter bit VS_ACTIVE  = 1'b1,
  parameter int CW         = 10,
  parameter int FW         = 20,
  parameter int SYNC_DELAY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic          hsync,
  output logic          vsync,
  output logic          display_on,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

  localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VISIBLE    = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_VISIBLE    = CW'(V_DISPLAY);
  localparam logic [CW-1:0] H_SYNC_FIRST = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] H_SYNC_LAST  = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] V_SYNC_FIRST = CW'(V_DISPLAY + V_BOTTOM);
  localparam logic [CW-1:0] V_SYNC_LAST  = CW'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

  // Reject geometries whose last column/line cannot be represented in CW
  // bits, empty sync pulses, or a negative alignment depth.
  generate
    if ((CW < 1) || (FW < 1) || (H_SYNC < 1) || (V_SYNC < 1) ||
        (H_DISPLAY < 1) || (V_DISPLAY < 1) || (SYNC_DELAY < 0) ||
        ((CW < 31) && ((H_TOTAL > (1 << CW)) || (V_TOTAL > (1 << CW))))) begin : g_bad_cfg
      $error("vga_timing_gen: invalid geometry or width parameters");
    end
  endgenerate

  // Next-state counters and strobes
  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;
  logic [FW-1:0] fc_next;
  logic          h_wrap;
  logic          v_wrap;
  logic          ls_next;
  logic          fs_next;
  logic          hs_next;
  logic          vs_next;
  logic          de_next;

  // Registered, undelayed qualifiers
  logic hs_q;
  logic vs_q;
  logic de_q;
  logic ls_q;
  logic fs_q;

  // Raster advance: hold without pix_en, otherwise step the column and
  // carry into the line and frame counters at the wrap points.
  always_comb begin
    h_next  = hpos;
    v_next  = vpos;
    fc_next = frame_count;
    ls_next = 1'b0;
    fs_next = 1'b0;
    h_wrap  = (hpos == H_LAST);
    v_wrap  = (vpos == V_LAST);
    if (pix_en) begin
      if (h_wrap) begin
        h_next  = '0;
        ls_next = 1'b1;
        if (v_wrap) begin
          v_next  = '0;
          fs_next = 1'b1;
          fc_next = frame_count + FW'(1);
        end else begin
          v_next = vpos + CW'(1);
        end
      end else begin
        h_next = hpos + CW'(1);
      end
    end
  end

  // Sync and blanking decode taken from the next-state position so the
  // registered outputs line up with the counters they describe.
  always_comb begin
    hs_next = ~HS_ACTIVE;
    vs_next = ~VS_ACTIVE;
    if ((h_next >= H_SYNC_FIRST) && (h_next <= H_SYNC_LAST)) begin
      hs_next = HS_ACTIVE;
    end
    if ((v_next >= V_SYNC_FIRST) && (v_next <= V_SYNC_LAST)) begin
      vs_next = VS_ACTIVE;
    end
    de_next = (h_next < H_VISIBLE) && (v_next < V_VISIBLE);
  end

  // Position counters, frame counter and undelayed qualifier registers;
  // reset lands on (0,0), which is visible and outside both sync regions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos        <= '0;
      vpos        <= '0;
      frame_count <= '0;
      hs_q        <= ~HS_ACTIVE;
      vs_q        <= ~VS_ACTIVE;
      de_q        <= 1'b1;
      ls_q        <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      hpos        <= h_next;
      vpos        <= v_next;
      frame_count <= fc_next;
      hs_q        <= hs_next;
      vs_q        <= vs_next;
      de_q        <= de_next;
      ls_q        <= ls_next;
      fs_q        <= fs_next;
    end
  end

`ifdef VGA_TIMING_ALIGN_EN
  // Packed order of the aligned group: {hsync, vsync, display_on, line_start, frame_start}
  localparam logic [4:0] ALIGN_IDLE = {~HS_ACTIVE, ~VS_ACTIVE, 3'b000};

  generate
    if (SYNC_DELAY == 0) begin : g_align_none
      assign {hsync, vsync, display_on, line_start, frame_start} =
             {hs_q, vs_q, de_q, ls_q, fs_q};
    end else begin : g_align_pipe
      logic [4:0] stage [SYNC_DELAY];

      // Fixed clk-count delay line, independent of pix_en; every stage
      // resets to the inactive pattern so nothing spurious leaks out.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC_DELAY; i++) begin
            stage[i] <= ALIGN_IDLE;
          end
        end else begin
          stage[0] <= {hs_q, vs_q, de_q, ls_q, fs_q};
          for (int i = 1; i < SYNC_DELAY; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign {hsync, vsync, display_on, line_start, frame_start} = stage[SYNC_DELAY-1];
    end
  endgenerate
`else
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign display_on  = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It supersedes the fixed 640x480 hvsync generator used by the demo tops and drives the pixel pipeline through `hpos`/`vpos`, `display_on` and the sync outputs. Compared with that generator it adds:
- configurable geometry and sync polarity;
- a pixel clock-enable for divided pixel rates;
- line/frame start strobes and a free-running frame counter;
- sync outputs coherent with the position counters on the same cycle;
- optional sync delay alignment.

## Interface
Parameters:
- `H_DISPLAY`, 640, visible pixels per line
- `H_FRONT`, 16, front porch pixels
- `H_SYNC`, 96, sync pixels
- `H_BACK`, 48, back porch pixels
- `V_DISPLAY`, 480, visible lines
- `V_BOTTOM`, 10, bottom porch lines
- `V_SYNC`, 2, sync lines
- `V_TOP`, 33, top porch lines
- `HS_ACTIVE`, 1, level of `hsync` during sync (0 = active-low)
- `VS_ACTIVE`, 1, level of `vsync` during sync
- `CW`, 10, width of `hpos`/`vpos`; H_TOTAL-1 and V_TOTAL-1 must fit
- `FW`, 20, width of `frame_count`
- `SYNC_DELAY`, 2, alignment depth in clk cycles; used only with `VGA_TIMING_ALIGN_EN`

Ports:
- `clk`  in  1  clock; the only clock
- `rst_n`  in  1  reset, synchronous, active-low
- `pix_en`  in  1  pixel advance enable; tie high for one pixel per clk
- `hpos`  out  CW  current pixel column, 0..H_TOTAL-1
- `vpos`  out  CW  current line, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, polarity per HS_ACTIVE
- `vsync`  out  1  vertical sync, polarity per VS_ACTIVE
- `display_on`  out  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY
- `line_start`  out  1  one-clk pulse at the start of each line
- `frame_start`  out  1  one-clk pulse at the start of each frame
- `frame_count`  out  FW  completed-frame counter, wraps modulo 2^FW

## Operation
- Derived constants: H_TOTAL = sum of the four H params; V_TOTAL = sum of the four V params.
- hsync region: hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1].
- vsync region: vpos in [V_DISPLAY+V_BOTTOM, V_DISPLAY+V_BOTTOM+V_SYNC-1].
- Counter advance on a clk edge with pix_en=1:
  - If hpos=H_TOTAL-1, hpos goes to 0. vpos then increments, or wraps to 0 if vpos=V_TOTAL-1.
  - Otherwise hpos increments.
- With pix_en=0, hpos, vpos and frame_count hold.
- `hsync`, `vsync` and `display_on` are registered. They are computed from the next-state counters, so on every cycle they describe the hpos/vpos presented on that same cycle; there is no one-cycle sync skew.
- `line_start` is registered. It is high for exactly one clk cycle: the cycle in which hpos first becomes 0 after a wrap. It stays low on the following cycles even if pix_en is low and hpos remains 0.
- `frame_start` follows the same rule for the transition to hpos=0, vpos=0. `line_start` is also high on that cycle.
- `frame_count` increments on the same edge that raises `frame_start`, wrapping from 2^FW-1 to 0.
- Reset (rst_n=0 at a clk edge) takes priority over pix_en at any point in the frame:
  - hpos=0, vpos=0, frame_count=0
  - hsync=~HS_ACTIVE, vsync=~VS_ACTIVE, display_on=1
  - line_start=0, frame_start=0
- The first frame after reset is not strobed. Strobes begin at the first wrap to (0,0).

## Timing
- Counter-to-sync latency is 0 cycles. Without the macro, all outputs update on the same clk edge.
- With pix_en=1, the line period is H_TOTAL clk and the frame period is H_TOTAL*V_TOTAL clk.
- With pix_en asserted every Nth clk, periods scale by N. Strobes remain one clk wide.
- Simultaneous last pixel of the last line and pix_en=1: the counters wrap to (0,0), frame_count increments, and both strobes pulse, all on one edge.

## Configuration
- Macro: `VGA_TIMING_ALIGN_EN`.
- Defined: `hsync`, `vsync`, `display_on`, `line_start` and `frame_start` each pass through a SYNC_DELAY-stage clk shift register. This matches downstream pipelined pixel logic.
  - The delay counts clk cycles regardless of pix_en.
  - All stages reset to inactive: syncs to their inactive levels, display_on=0, strobes=0.
  - hpos, vpos and frame_count are not delayed.
- Undefined: SYNC_DELAY is ignored and there is no delay logic.

## Test plan
- Reset default params, then hold pix_en=1 for 420000 clk. Required:
  - hpos wraps 799->0 every 800 clk.
  - vpos wraps 524->0.
  - frame_start pulses once, at clk 420000; frame_count=1 afterwards.
- Default params, pix_en=1. Required:
  - hsync=1 exactly while hpos in 656..751.
  - vsync=1 exactly while vpos in 490..491.
  - display_on=0 at hpos=640 and at vpos=480.
  - Outputs coherent with hpos/vpos on every cycle.
- HS_ACTIVE=0, VS_ACTIVE=0. Required: hsync low only for hpos 656..751; vsync low only for lines 490..491; both high after reset.
- pix_en toggling 1,0,1,0. Required:
  - Line period 1600 clk.
  - line_start high for a single clk per line.
  - Counters hold on pix_en=0 cycles.
- Assert rst_n=0 for one cycle at hpos=300, vpos=200, frame_count=5. Required: next cycle hpos=0, vpos=0, frame_count=0, strobes 0, and no frame_start until 420000 clk later.
- With VGA_TIMING_ALIGN_EN defined and SYNC_DELAY=2. Required: hsync rises 2 clk after hpos=656 appears; frame_start lags the (0,0) wrap by 2 clk; hpos is undelayed.
